// File: rtl/rgb_pwm_capture_if.sv
// rgb_pwm_capture_if: the three PWM lines going into the capture block and
// the recovered per-channel high-times, valid flag and update strobe coming out.
interface rgb_pwm_capture_if;
   logic       R_in;
   logic       G_in;
   logic       B_in;
   logic [7:0] R_time_out;
   logic [7:0] G_time_out;
   logic [7:0] B_time_out;
   logic       valid;
   logic       update;

   modport master (
      output R_in, G_in, B_in,
      input  R_time_out, G_time_out, B_time_out, valid, update
   );

   modport slave (
      input  R_in, G_in, B_in,
      output R_time_out, G_time_out, B_time_out, valid, update
   );
endinterface

// File: rtl/rgb_pwm_capture.sv
// rgb_pwm_capture: measures the high-time of the R/G/B PWM lines over a
// free-running window of PERIOD cycles and publishes each channel's count
// once it has repeated for STABLE consecutive windows.
module rgb_pwm_capture #(
   parameter int PERIOD = 256,
   parameter int STABLE = 2
) (
   input logic              clk,
   input logic              rst,
   rgb_pwm_capture_if.slave pwm
);

   localparam int               WIN_W     = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam logic [WIN_W-1:0] WIN_LAST  = WIN_W'(PERIOD - 1);
   localparam logic [2:0]       AGREE_MAX = 3'(STABLE);

   // Channel index 0 = R, 1 = G, 2 = B throughout.
   logic [2:0]       pwm_raw;
   logic [2:0]       sync_1;
   logic [2:0]       sync_2;
   logic [WIN_W-1:0] win_cnt;
   logic             win_end;
   logic [8:0]       hi_cnt   [3];
   logic [8:0]       hi_next  [3];
   logic [7:0]       clamped  [3];
   logic [7:0]       last     [3];
   logic [2:0]       agree    [3];
   logic [7:0]       time_out [3];
   logic [2:0]       publish;
   logic [2:0]       changing;
   logic [2:0]       pub;
   logic             update_r;

   assign pwm_raw = {pwm.B_in, pwm.G_in, pwm.R_in};
   assign win_end = (win_cnt == WIN_LAST);

   // Two-flop synchronizer; the PWM lines may come from another clock domain.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_1 <= '0;
         sync_2 <= '0;
      end else begin
         sync_1 <= pwm_raw;
         sync_2 <= sync_1;
      end
   end

   // Shared free-running window counter; windows need no alignment to the PWM frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         win_cnt <= '0;
      end else if (win_end) begin
         win_cnt <= '0;
      end else begin
         win_cnt <= win_cnt + 1'b1;
      end
   end

   // Running count including this cycle's sample, the clamp of a full-high window
   // to 255, and whether each channel is ready to (re)publish.
   always_comb begin
      publish  = '0;
      changing = '0;
      for (int i = 0; i < 3; i++) begin
         hi_next[i]  = hi_cnt[i] + {8'd0, sync_2[i]};
         clamped[i]  = hi_next[i][8] ? 8'hFF : hi_next[i][7:0];
         publish[i]  = (agree[i] == AGREE_MAX);
         changing[i] = publish[i] && (last[i] != time_out[i]);
      end
   end

   // High counting per window and the agreement tracker fed by each finished window.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 3; i++) begin
            hi_cnt[i] <= '0;
            last[i]   <= '0;
            agree[i]  <= '0;
         end
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (win_end) begin
               hi_cnt[i] <= '0;
               if (clamped[i] == last[i]) begin
                  if (agree[i] < AGREE_MAX) begin
                     agree[i] <= agree[i] + 3'd1;
                  end
               end else begin
                  last[i]  <= clamped[i];
                  agree[i] <= 3'd1;
               end
            end else begin
               hi_cnt[i] <= hi_next[i];
            end
         end
      end
   end

   // Publish stable values; a republish of the same value neither changes the output nor pulses update.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 3; i++) begin
            time_out[i] <= '0;
         end
         pub      <= '0;
         update_r <= 1'b0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (publish[i]) begin
               pub[i] <= 1'b1;
            end
            if (changing[i]) begin
               time_out[i] <= last[i];
            end
         end
         update_r <= |changing;
      end
   end

   assign pwm.R_time_out = time_out[0];
   assign pwm.G_time_out = time_out[1];
   assign pwm.B_time_out = time_out[2];
   assign pwm.valid      = &pub;
   assign pwm.update     = update_r;

endmodule

// File: doc/rgb_pwm_capture.md
# rgb_pwm_capture

Measures the duty cycle of the three RGB PWM lines and recovers the 8-bit R/G/B time values that produced them. It is the receive-side counterpart of the RGB PWM generator: it sits in a loopback or monitor path, sampling `R_in`/`G_in`/`B_in` on the system clock. It publishes each channel's measured high-time only after the value has been stable for a programmable number of consecutive PWM windows.

## Interface
- `PERIOD`, 256: PWM period in `clk` cycles; also the measurement window length. Must be a power of two, at most 256.
- `STABLE`, 2: number of consecutive identical window counts required before an output updates. Range 1..7.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `R_in`, `G_in`, `B_in`  in  1 each  PWM lines. These are not assumed synchronous to `clk`.
- `R_time_out`, `G_time_out`, `B_time_out`  out  8 each  published high-time per channel.
- `valid`  out  1  high once every channel has published at least once since reset.
- `update`  out  1  one-cycle pulse on any cycle in which at least one `*_time_out` changes value.

## Operation
**Input synchronizer**
- Each input passes through a 2-flop synchronizer.
- Only the synchronized signal `*_s` is used downstream.

**Window counter**
- `win_cnt` is free-running, counting 0..`PERIOD`-1 and wrapping to 0.
- It is shared by all channels.
- Windows are not aligned to the PWM frame. For a periodic input, any `PERIOD`-cycle window contains exactly the high-time, so no alignment is needed.

**High counter (per channel)**
- `hi_cnt` is 9 bits wide and increments on each cycle where `*_s`=1.
- On the cycle where `win_cnt`=`PERIOD`-1, that cycle's sample is included. The finished count then goes to the stability stage, and `hi_cnt` restarts at 0 (or 1 if sampled high on the first cycle of the next window). No sample is dropped or counted twice across the wrap.
- A count of 256 (input constant high) is clamped to 255 before comparison.

**Stability stage (per channel, 3-bit `agree`)**
- If the clamped count equals the stored `last`: `agree` increments, saturating at `STABLE`.
- Otherwise: `last` takes the new count and `agree` is set to 1.
- When `agree` reaches `STABLE` and `last` differs from `*_time_out`: `*_time_out` takes `last`.
- A channel's `pub` flag is set on its first publish and stays set. `valid` is the AND of all three `pub` flags.

**Reset**
- Asynchronous reset clears synchronizers, `win_cnt`, all `hi_cnt`, `last`, `agree`, `pub`, all `*_time_out` (0), `valid` (0) and `update` (0).
- Reset mid-window discards the partial window. The first window after reset starts at `win_cnt`=0.

## Timing
- `*_time_out` and `update` are registered. They change on the edge after the window-end cycle on which `agree` reaches `STABLE`.
- Latency from a new steady input duty to the published output:
  - 2 cycles of synchronizer delay, then
  - up to (`STABLE`+1)×`PERIOD` cycles, then
  - 1 cycle.
  - The extra window covers the mixed window straddling the change.
- With defaults and a steady input from reset, the first publish occurs at cycle 2×256+3 ±1 of synchronizer alignment.
  - If the first window catches only part of the input due to synchronizer fill, publish slips by one window.
  - The bench must tolerate ±1 window.
- If channels publish on the same cycle, `update` is a single pulse.
- If a republish yields the value already on the output, nothing changes and there is no `update`.
- Duty 0 publishes 0. Constant-high publishes 255, which is indistinguishable from a generator value of 255 (255 high of 256).

## Test plan
1. Reset, then R=0x40, G=0x80, B=0x00 PWM (period 256) → `valid` rises within 4 windows; outputs are 0x40/0x80/0x00; exactly one `update` pulse.
2. Steady state, then change G from 0x80 to 0x10 → within 3 windows + 3 cycles, `G_time_out`=0x10. It never shows the intermediate mixed value. R and B are unchanged. One `update` pulse.
3. R held constant 1 and B constant 0 → `R_time_out`=0xFF, `B_time_out`=0x00. No overflow into other bits.
4. B toggling between 0x20 and 0x60 every window (never `STABLE` agreements) → `B_time_out` holds its previous value with no `update`, while other channels still update normally.
5. Assert `rst` asynchronously mid-window after outputs are valid → outputs go to 0 and `valid`=0 immediately, without waiting for a clock edge. After release, values reappear per scenario 1 timing.
6. `PERIOD`=16, `STABLE`=1, with input duty 5/16 → `*_time_out`=5 after ≤2 windows. Also check the boundary where `*_s` is high on the last and first cycle of a window: counts stay exactly 5.
